// File: rtl/pipe_ctrl_unit_if.sv
// Control-unit bus: ID-stage instruction and branch outcome in, pipeline
// control bits, forwarding selects and stall/flush requests out.
interface pipe_ctrl_unit_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [31:0]       id_instr;
  logic              ex_branch_taken;
  logic              pc_stall;
  logic              ifid_stall;
  logic              ifid_flush;
  logic              id_jump;
  logic              id_sign_ext;
  logic              ex_alu_src;
  logic [2:0]        ex_alu_op;
  logic              ex_branch;
  logic              ex_branch_ne;
  logic              ex_link;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              mem_read;
  logic              mem_write;
  logic              wb_reg_write;
  logic              wb_mem_to_reg;
  logic [REG_AW-1:0] wb_dst;
  logic              illegal_op;

  modport master (
    output id_valid, id_instr, ex_branch_taken,
    input  pc_stall, ifid_stall, ifid_flush, id_jump, id_sign_ext,
           ex_alu_src, ex_alu_op, ex_branch, ex_branch_ne, ex_link,
           fwd_a, fwd_b, mem_read, mem_write, wb_reg_write, wb_mem_to_reg,
           wb_dst, illegal_op
  );

  modport slave (
    input  id_valid, id_instr, ex_branch_taken,
    output pc_stall, ifid_stall, ifid_flush, id_jump, id_sign_ext,
           ex_alu_src, ex_alu_op, ex_branch, ex_branch_ne, ex_link,
           fwd_a, fwd_b, mem_read, mem_write, wb_reg_write, wb_mem_to_reg,
           wb_dst, illegal_op
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Main control for a 5-stage pipeline: ID decode, control word carried through
// ID/EX, EX/MEM and MEM/WB, load-use / RAW stalls, branch/jump flush, forwarding.
module pipe_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31,
  parameter bit FWD_EN   = 1'b1
) (
  input logic            clk,
  input logic            rst,
  pipe_ctrl_unit_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b110;

  typedef struct packed {
    logic              rw;
    logic              m2r;
    logic              mr;
    logic              mw;
    logic              src;
    logic              sext;
    logic [2:0]        op;
    logic              br;
    logic              ne;
    logic              jump;
    logic              link;
    logic              rs_used;
    logic              rt_used;
    logic              ill;
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } dec_t;

  typedef struct packed {
    logic              rw;
    logic              m2r;
    logic              mr;
    logic              mw;
    logic              src;
    logic [2:0]        op;
    logic              br;
    logic              ne;
    logic              link;
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } idex_t;

  dec_t              id_dec;
  idex_t             idex_q, idex_d;
  logic              exmem_rw_q, exmem_m2r_q, exmem_mr_q, exmem_mw_q;
  logic [REG_AW-1:0] exmem_dst_q;
  logic              memwb_rw_q, memwb_m2r_q;
  logic [REG_AW-1:0] memwb_dst_q;
  logic              illegal_q, illegal_d;

  logic              load_use, raw_stall, branch_flush, stall, jump_go;
  logic              unused_bits;

  logic [5:0]        opcode;
  logic [REG_AW-1:0] f_rs, f_rt, f_rd;

  assign opcode = bus.id_instr[31:26];
  assign f_rs   = REG_AW'(bus.id_instr[25:21]);
  assign f_rt   = REG_AW'(bus.id_instr[20:16]);
  assign f_rd   = REG_AW'(bus.id_instr[15:11]);

  always_comb begin
    id_dec = '0;
    if (bus.id_valid) begin
      id_dec.rs = f_rs;
      id_dec.rt = f_rt;
      case (opcode)
        OP_RTYPE: begin
          id_dec.rw = 1'b1; id_dec.dst = f_rd; id_dec.op = ALU_FUNCT;
          id_dec.rs_used = 1'b1; id_dec.rt_used = 1'b1;
        end
        OP_LW: begin
          id_dec.rw = 1'b1; id_dec.m2r = 1'b1; id_dec.mr = 1'b1;
          id_dec.src = 1'b1; id_dec.sext = 1'b1; id_dec.op = ALU_ADD;
          id_dec.dst = f_rt; id_dec.rs_used = 1'b1;
        end
        OP_SW: begin
          id_dec.mw = 1'b1; id_dec.src = 1'b1; id_dec.sext = 1'b1;
          id_dec.op = ALU_ADD; id_dec.rs_used = 1'b1; id_dec.rt_used = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          id_dec.br = 1'b1; id_dec.ne = (opcode == OP_BNE);
          id_dec.sext = 1'b1; id_dec.op = ALU_SUB;
          id_dec.rs_used = 1'b1; id_dec.rt_used = 1'b1;
        end
        OP_ADDI, OP_ADDIU: begin
          id_dec.rw = 1'b1; id_dec.src = 1'b1; id_dec.sext = 1'b1;
          id_dec.op = ALU_ADD; id_dec.dst = f_rt; id_dec.rs_used = 1'b1;
        end
        OP_ANDI, OP_ORI, OP_LUI, OP_SLTI: begin
          id_dec.rw = 1'b1; id_dec.src = 1'b1; id_dec.dst = f_rt;
          id_dec.rs_used = (opcode != OP_LUI);
          id_dec.sext = (opcode == OP_SLTI);
          case (opcode)
            OP_ANDI: id_dec.op = ALU_AND;
            OP_ORI:  id_dec.op = ALU_OR;
            OP_LUI:  id_dec.op = ALU_LUI;
            default: id_dec.op = ALU_SLT;
          endcase
        end
        OP_J: id_dec.jump = 1'b1;
        OP_JAL: begin
          id_dec.jump = 1'b1; id_dec.rw = 1'b1; id_dec.link = 1'b1;
          id_dec.dst = REG_AW'(LINK_REG);
        end
        default: begin
          id_dec     = '0;
          id_dec.ill = 1'b1;
        end
      endcase
    end
  end

  // A zero destination never creates a dependency.
  function automatic logic src_hit(input dec_t d, input logic [REG_AW-1:0] dst);
    return (dst != '0) && ((d.rs_used && d.rs == dst) || (d.rt_used && d.rt == dst));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] tag,
                                         input logic mem_rw, input logic [REG_AW-1:0] mem_dst,
                                         input logic wb_rw, input logic [REG_AW-1:0] wb_dst);
    if (mem_rw && mem_dst != '0 && mem_dst == tag) return 2'b10;
    if (wb_rw && wb_dst != '0 && wb_dst == tag)    return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    load_use     = idex_q.mr & src_hit(id_dec, idex_q.dst);
    raw_stall    = 1'b0;
    if (!FWD_EN) begin
      raw_stall = (idex_q.rw & src_hit(id_dec, idex_q.dst)) |
                  (exmem_rw_q & src_hit(id_dec, exmem_dst_q));
    end
    branch_flush = idex_q.br & (bus.ex_branch_taken ^ idex_q.ne);
    stall        = (load_use | raw_stall) & ~branch_flush;
    jump_go      = id_dec.jump & ~stall & ~branch_flush;
    illegal_d    = id_dec.ill & ~stall & ~branch_flush;
  end

  always_comb begin
    idex_d = '0;
    if (!stall && !branch_flush) begin
      idex_d.rw   = id_dec.rw;
      idex_d.m2r  = id_dec.m2r;
      idex_d.mr   = id_dec.mr;
      idex_d.mw   = id_dec.mw;
      idex_d.src  = id_dec.src;
      idex_d.op   = id_dec.op;
      idex_d.br   = id_dec.br;
      idex_d.ne   = id_dec.ne;
      idex_d.link = id_dec.link;
      idex_d.dst  = id_dec.dst;
      idex_d.rs   = id_dec.rs;
      idex_d.rt   = id_dec.rt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q      <= '0;
      exmem_rw_q  <= 1'b0;
      exmem_m2r_q <= 1'b0;
      exmem_mr_q  <= 1'b0;
      exmem_mw_q  <= 1'b0;
      exmem_dst_q <= '0;
      memwb_rw_q  <= 1'b0;
      memwb_m2r_q <= 1'b0;
      memwb_dst_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      idex_q      <= idex_d;
      exmem_rw_q  <= idex_q.rw;
      exmem_m2r_q <= idex_q.m2r;
      exmem_mr_q  <= idex_q.mr;
      exmem_mw_q  <= idex_q.mw;
      exmem_dst_q <= idex_q.dst;
      memwb_rw_q  <= exmem_rw_q;
      memwb_m2r_q <= exmem_m2r_q;
      memwb_dst_q <= exmem_dst_q;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.pc_stall      = stall;
  assign bus.ifid_stall    = stall;
  assign bus.ifid_flush    = branch_flush | jump_go;
  assign bus.id_jump       = jump_go;
  assign bus.id_sign_ext   = id_dec.sext;
  assign bus.ex_alu_src    = idex_q.src;
  assign bus.ex_alu_op     = idex_q.op;
  assign bus.ex_branch     = idex_q.br;
  assign bus.ex_branch_ne  = idex_q.ne;
  assign bus.ex_link       = idex_q.link;
  assign bus.fwd_a         = FWD_EN ? fwd_sel(idex_q.rs, exmem_rw_q, exmem_dst_q,
                                              memwb_rw_q, memwb_dst_q) : 2'b00;
  assign bus.fwd_b         = FWD_EN ? fwd_sel(idex_q.rt, exmem_rw_q, exmem_dst_q,
                                              memwb_rw_q, memwb_dst_q) : 2'b00;
  assign bus.mem_read      = exmem_mr_q;
  assign bus.mem_write     = exmem_mw_q;
  assign bus.wb_reg_write  = memwb_rw_q;
  assign bus.wb_mem_to_reg = memwb_m2r_q;
  assign bus.wb_dst        = memwb_dst_q;
  assign bus.illegal_op    = illegal_q;

  // Immediate/funct bits belong to the datapath; tags go unused without forwarding.
  assign unused_bits = ^{bus.id_instr[10:0], idex_q.rs, idex_q.rt};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two instances (forwarding on/off) checked against
// an instruction-level pipeline model, directed scenarios plus random traffic.
module tb_pipe_ctrl_unit;

  logic clk = 1'b0;
  logic rst;
  logic tb_valid;
  logic [31:0] tb_instr;
  logic tb_taken;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit_if #(.REG_AW(5)) bus1 ();
  pipe_ctrl_unit_if #(.REG_AW(5)) bus0 ();

  assign bus1.id_valid = tb_valid;
  assign bus1.id_instr = tb_instr;
  assign bus1.ex_branch_taken = tb_taken;
  assign bus0.id_valid = tb_valid;
  assign bus0.id_instr = tb_instr;
  assign bus0.ex_branch_taken = tb_taken;

  pipe_ctrl_unit #(.REG_AW(5), .LINK_REG(31), .FWD_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pipe_ctrl_unit #(.REG_AW(5), .LINK_REG(31), .FWD_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  logic [25:0] v1, v0;
  assign v1 = {bus1.pc_stall, bus1.ifid_stall, bus1.ifid_flush, bus1.id_jump, bus1.id_sign_ext,
               bus1.ex_alu_src, bus1.ex_alu_op, bus1.ex_branch, bus1.ex_branch_ne, bus1.ex_link,
               bus1.fwd_a, bus1.fwd_b, bus1.mem_read, bus1.mem_write, bus1.wb_reg_write,
               bus1.wb_mem_to_reg, bus1.wb_dst, bus1.illegal_op};
  assign v0 = {bus0.pc_stall, bus0.ifid_stall, bus0.ifid_flush, bus0.id_jump, bus0.id_sign_ext,
               bus0.ex_alu_src, bus0.ex_alu_op, bus0.ex_branch, bus0.ex_branch_ne, bus0.ex_link,
               bus0.fwd_a, bus0.fwd_b, bus0.mem_read, bus0.mem_write, bus0.wb_reg_write,
               bus0.wb_mem_to_reg, bus0.wb_dst, bus0.illegal_op};

  // One in-flight instruction's control record, as the decode table defines it.
  typedef struct packed {
    logic rw, m2r, mr, mw, src, sext;
    logic [2:0] op;
    logic br, ne, jump, link, rsu, rtu, ill;
    logic [4:0] dst, rs, rt;
  } inst_t;

  typedef struct packed {
    inst_t ex, mem, wb;
    logic  ill;
  } mstate_t;

  mstate_t m1, m0;

  function automatic inst_t decode(input logic v, input logic [31:0] ins);
    inst_t d = '0;
    if (!v) return d;
    d.rs = ins[25:21];
    d.rt = ins[20:16];
    case (ins[31:26])
      6'd0:  begin d.rw = 1; d.dst = ins[15:11]; d.op = 3'd2; d.rsu = 1; d.rtu = 1; end
      6'd35: begin d.rw = 1; d.m2r = 1; d.mr = 1; d.src = 1; d.sext = 1; d.dst = d.rt; d.rsu = 1; end
      6'd43: begin d.mw = 1; d.src = 1; d.sext = 1; d.rsu = 1; d.rtu = 1; end
      6'd4:  begin d.br = 1; d.sext = 1; d.op = 3'd1; d.rsu = 1; d.rtu = 1; end
      6'd5:  begin d.br = 1; d.ne = 1; d.sext = 1; d.op = 3'd1; d.rsu = 1; d.rtu = 1; end
      6'd8, 6'd9: begin d.rw = 1; d.src = 1; d.sext = 1; d.dst = d.rt; d.rsu = 1; end
      6'd12: begin d.rw = 1; d.src = 1; d.op = 3'd3; d.dst = d.rt; d.rsu = 1; end
      6'd13: begin d.rw = 1; d.src = 1; d.op = 3'd4; d.dst = d.rt; d.rsu = 1; end
      6'd15: begin d.rw = 1; d.src = 1; d.op = 3'd5; d.dst = d.rt; end
      6'd10: begin d.rw = 1; d.src = 1; d.sext = 1; d.op = 3'd6; d.dst = d.rt; d.rsu = 1; end
      6'd2:  d.jump = 1;
      6'd3:  begin d.jump = 1; d.rw = 1; d.link = 1; d.dst = 5'd31; end
      default: begin d = '0; d.ill = 1; end
    endcase
    return d;
  endfunction

  function automatic logic reads(input inst_t id, input logic [4:0] r);
    return r != 0 && ((id.rsu && id.rs == r) || (id.rtu && id.rt == r));
  endfunction

  function automatic logic m_flush(input mstate_t s);
    return s.ex.br && (tb_taken != s.ex.ne);
  endfunction

  function automatic logic m_stall(input mstate_t s, input bit fwd);
    inst_t id = decode(tb_valid, tb_instr);
    logic need;
    need = s.ex.mr && reads(id, s.ex.dst);
    if (!fwd) need = need || (s.ex.rw && reads(id, s.ex.dst)) || (s.mem.rw && reads(id, s.mem.dst));
    return need && !m_flush(s);
  endfunction

  function automatic logic [1:0] m_fwd(input mstate_t s, input logic [4:0] r, input bit fwd);
    if (!fwd) return 2'b00;
    if (s.mem.rw && s.mem.dst != 0 && s.mem.dst == r) return 2'b10;
    if (s.wb.rw && s.wb.dst != 0 && s.wb.dst == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [25:0] exp_vec(input mstate_t s, input bit fwd);
    inst_t id = decode(tb_valid, tb_instr);
    logic st = m_stall(s, fwd);
    logic fl = m_flush(s);
    logic jg = id.jump && !st && !fl;
    return {st, st, fl | jg, jg, id.sext, s.ex.src, s.ex.op, s.ex.br, s.ex.ne, s.ex.link,
            m_fwd(s, s.ex.rs, fwd), m_fwd(s, s.ex.rt, fwd), s.mem.mr, s.mem.mw,
            s.wb.rw, s.wb.m2r, s.wb.dst, s.ill};
  endfunction

  function automatic mstate_t next_st(input mstate_t s, input bit fwd);
    mstate_t n;
    inst_t id = decode(tb_valid, tb_instr);
    logic issue = !m_stall(s, fwd) && !m_flush(s);
    if (rst) return '0;
    n.wb  = s.mem;
    n.mem = s.ex;
    n.ex  = (issue && !id.ill) ? id : '0;
    n.ill = issue && id.ill;
    return n;
  endfunction

  function automatic logic [31:0] rt_ins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'd0, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'h0004};
  endfunction

  task automatic advance();
    mstate_t n1, n0;
    n1 = next_st(m1, 1'b1);
    n0 = next_st(m0, 1'b0);
    @(posedge clk);
    m1 = n1;
    m0 = n0;
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic tk);
    tb_valid = v;
    tb_instr = ins;
    tb_taken = tk;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      advance();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    advance();
    advance();
    rst = 1'b0;
    #1;
    tests++;
    if (v1 !== 26'h0) begin fails++; $display("FAIL reset_fwd1: got %h want 0", v1); end
    tests++;
    if (v0 !== 26'h0) begin fails++; $display("FAIL reset_fwd0: got %h want 0", v0); end
    $display("[TB] reset: outputs %h / %h", v1, v0);
  endtask

  task automatic test_load_use();
    idle(4);
    drive(1'b1, i_ins(6'd35, 5'd1, 5'd2), 1'b0);
    advance();
    drive(1'b1, rt_ins(5'd2, 5'd4, 5'd3, 6'h20), 1'b0);
    tests++;
    if (bus1.pc_stall !== 1'b1 || bus1.ifid_stall !== 1'b1) begin
      fails++; $display("FAIL load_use_stall: got %b%b want 11", bus1.pc_stall, bus1.ifid_stall);
    end
    advance();
    #1;
    tests++;
    if (bus1.pc_stall !== 1'b0 || bus1.ex_alu_src !== 1'b0 || bus1.mem_read !== 1'b1) begin
      fails++; $display("FAIL load_use_bubble: stall %b src %b mrd %b want 0 0 1",
                        bus1.pc_stall, bus1.ex_alu_src, bus1.mem_read);
    end
    tests++;
    if (v0 !== exp_vec(m0, 1'b0)) begin fails++; $display("FAIL load_use_fwd0: got %h want %h", v0, exp_vec(m0, 1'b0)); end
    advance();
    drive(1'b0, 32'h0, 1'b0);
    tests++;
    if (bus1.fwd_a !== 2'b01 || bus1.fwd_b !== 2'b00 || bus1.ex_alu_op !== 3'b010) begin
      fails++; $display("FAIL load_use_fwd: fwd_a %b fwd_b %b op %b want 01 00 010",
                        bus1.fwd_a, bus1.fwd_b, bus1.ex_alu_op);
    end
    $display("[TB] load_use: fwd_a=%b after one stall cycle", bus1.fwd_a);
    advance();
  endtask

  task automatic test_forward();
    int stalls0 = 0;
    idle(4);
    drive(1'b1, rt_ins(5'd1, 5'd1, 5'd2, 6'h20), 1'b0);
    advance();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, rt_ins(5'd2, 5'd2, 5'd5, 6'h22), 1'b0);
      stalls0 += int'(bus0.pc_stall);
      tests++;
      if (bus1.pc_stall !== 1'b0) begin fails++; $display("FAIL fwd_nostall c%0d: got %b want 0", c, bus1.pc_stall); end
      if (c == 1) begin
        tests++;
        if (bus1.fwd_a !== 2'b10 || bus1.fwd_b !== 2'b10) begin
          fails++; $display("FAIL fwd_exmem: fwd_a %b fwd_b %b want 10 10", bus1.fwd_a, bus1.fwd_b);
        end
      end
      advance();
    end
    tests++;
    if (stalls0 != 2) begin fails++; $display("FAIL nofwd_stall_cycles: got %0d want 2", stalls0); end
    idle(4);
    drive(1'b1, rt_ins(5'd1, 5'd1, 5'd0, 6'h20), 1'b0);
    advance();
    drive(1'b1, rt_ins(5'd0, 5'd0, 5'd5, 6'h22), 1'b0);
    advance();
    drive(1'b0, 32'h0, 1'b0);
    tests++;
    if (bus1.fwd_a !== 2'b00 || bus1.fwd_b !== 2'b00) begin
      fails++; $display("FAIL fwd_dst0: fwd_a %b fwd_b %b want 00 00", bus1.fwd_a, bus1.fwd_b);
    end
    $display("[TB] forward: fwd_dst0 %b%b, no-fwd stalls %0d", bus1.fwd_a, bus1.fwd_b, stalls0);
    advance();
  endtask

  task automatic test_branch();
    idle(4);
    drive(1'b1, rt_ins(5'd1, 5'd1, 5'd2, 6'h20), 1'b0);
    advance();
    drive(1'b1, i_ins(6'd4, 5'd1, 5'd1), 1'b0);
    advance();
    drive(1'b1, rt_ins(5'd2, 5'd2, 5'd5, 6'h22), 1'b1);
    tests++;
    if (bus1.ifid_flush !== 1'b1 || bus1.pc_stall !== 1'b0) begin
      fails++; $display("FAIL branch_flush1: flush %b stall %b want 1 0", bus1.ifid_flush, bus1.pc_stall);
    end
    tests++;
    if (bus0.ifid_flush !== 1'b1 || bus0.pc_stall !== 1'b0 || bus0.ifid_stall !== 1'b0) begin
      fails++; $display("FAIL branch_over_stall: flush %b stall %b want 1 0", bus0.ifid_flush, bus0.pc_stall);
    end
    advance();
    drive(1'b0, 32'h0, 1'b0);
    tests++;
    if (bus1.ex_branch !== 1'b0 || bus1.ex_alu_op !== 3'b000 || bus0.ex_alu_op !== 3'b000) begin
      fails++; $display("FAIL branch_bubble: br %b op %b/%b want 0 000", bus1.ex_branch, bus1.ex_alu_op, bus0.ex_alu_op);
    end
    $display("[TB] branch: taken beq flushed, ex op %b", bus1.ex_alu_op);
    advance();
  endtask

  task automatic test_jal();
    logic [31:0] ins;
    idle(4);
    ins = {6'd3, 26'h0000123};
    drive(1'b1, ins, 1'b0);
    tests++;
    if (bus1.id_jump !== 1'b1 || bus1.ifid_flush !== 1'b1) begin
      fails++; $display("FAIL jal_id: jump %b flush %b want 1 1", bus1.id_jump, bus1.ifid_flush);
    end
    advance();
    drive(1'b0, 32'h0, 1'b0);
    tests++;
    if (bus1.ex_link !== 1'b1) begin fails++; $display("FAIL jal_link: got %b want 1", bus1.ex_link); end
    advance();
    advance();
    tests++;
    if (bus1.wb_reg_write !== 1'b1 || bus1.wb_dst !== 5'd31) begin
      fails++; $display("FAIL jal_wb: rw %b dst %0d want 1 31", bus1.wb_reg_write, bus1.wb_dst);
    end
    $display("[TB] jal: wb_dst=%0d", bus1.wb_dst);
    advance();
  endtask

  task automatic test_illegal();
    idle(4);
    drive(1'b1, 32'hFC00_0000, 1'b0);
    tests++;
    if (bus1.illegal_op !== 1'b0) begin fails++; $display("FAIL illegal_early: got %b want 0", bus1.illegal_op); end
    advance();
    drive(1'b0, 32'h0, 1'b0);
    tests++;
    if (bus1.illegal_op !== 1'b1 || v1[20:14] !== 7'h0) begin
      fails++; $display("FAIL illegal_pulse: ill %b ex bits %h want 1 0", bus1.illegal_op, v1[20:14]);
    end
    advance();
    tests++;
    if (bus1.illegal_op !== 1'b0) begin fails++; $display("FAIL illegal_one_cycle: got %b want 0", bus1.illegal_op); end
    $display("[TB] illegal: single pulse observed");
  endtask

  task automatic test_midreset();
    idle(2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i_ins(6'd35, 5'd1, 5'(i + 2)), 1'b0);
      advance();
    end
    rst = 1'b1;
    drive(1'b1, rt_ins(5'd1, 5'd1, 5'd3, 6'h20), 1'b0);
    advance();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tests++;
    if (v1 !== 26'h0 || v0 !== 26'h0 || bus1.wb_reg_write !== 1'b0) begin
      fails++; $display("FAIL midreset: got %h / %h want 0", v1, v0);
    end
    $display("[TB] midreset: outputs %h", v1);
  endtask

  task automatic test_random();
    logic [5:0] ops [15];
    logic [5:0] op;
    int bad = 0;
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd9, 6'd12, 6'd13, 6'd15, 6'd10, 6'd2, 6'd3, 6'd63, 6'd35};
    for (int c = 0; c < 500; c++) begin
      op  = ops[$urandom_range(0, 14)];
      rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 7) != 0,
            {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 11'($urandom)},
            1'($urandom));
      tests++;
      if (v1 !== exp_vec(m1, 1'b1)) begin
        fails++; bad++; $display("FAIL rand_fwd1 c%0d: got %h want %h", c, v1, exp_vec(m1, 1'b1));
      end
      tests++;
      if (v0 !== exp_vec(m0, 1'b0)) begin
        fails++; bad++; $display("FAIL rand_fwd0 c%0d: got %h want %h", c, v0, exp_vec(m0, 1'b0));
      end
      advance();
    end
    rst = 1'b0;
    $display("[TB] random: 500 cycles, %0d mismatching cycles", bad);
  endtask

  initial begin
    rst = 1'b1;
    tb_valid = 1'b0;
    tb_instr = 32'h0;
    tb_taken = 1'b0;
    m1 = '0;
    m0 = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_jal();
    test_illegal();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
